fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 24 ++
 rtl/fetch_unit_next_pc.sv | 41 ++++
 rtl/fetch_unit.sv | 92 +++++++++
 tb/tb_fetch_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
//------------------------------------------------------------------------------
// fetch_unit_pkg : shared encodings for the fetch unit and its next-PC logic
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fetch_unit_pkg;

  localparam int INST_W = 16;

  localparam logic [2:0] PC_INC = 3'd0;
  localparam logic [2:0] PC_REL = 3'd1;
  localparam logic [2:0] PC_ABS = 3'd2;
  localparam logic [2:0] PC_CBR = 3'd3;
  localparam logic [2:0] PC_RET = 3'd4;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_next_pc.sv
//------------------------------------------------------------------------------
// next_pc : combinational next-PC select (increment, relative, absolute,
//           conditional branch, return, hold).  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module next_pc
  import fetch_unit_pkg::*;
(
  input  logic [INST_W-1:0] pc,
  input  logic [INST_W-1:0] inst,
  input  logic [2:0]        pc_control,
  input  logic              cond,
  input  logic [INST_W-1:0] r_top,
  output logic [INST_W-1:0] npc
);

  logic [INST_W-1:0] pc_inc;
  logic [INST_W-1:0] pc_rel;
  logic [INST_W-1:0] pc_abs;

  // 16-bit adds truncate naturally, giving wrap in both directions
  assign pc_inc = pc + 16'd1;
  assign pc_rel = pc + {{4{inst[11]}}, inst[11:0]};
  assign pc_abs = {pc[15:12], inst[11:0]};

  always_comb begin
    npc = pc;
    case (pc_control)
      PC_INC:  npc = pc_inc;
      PC_REL:  npc = pc_rel;
      PC_ABS:  npc = pc_abs;
      PC_CBR:  npc = cond ? pc_rel : pc_inc;
      PC_RET:  npc = r_top;
      default: npc = pc;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
//------------------------------------------------------------------------------
// fetch_unit : two-state instruction fetch FSM with PC and instruction regs.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [2:0]  PCControl,
  input  logic        PCWrite,
  input  logic        cond,
  input  logic [15:0] rTop,
  output logic [15:0] imem_addr,
  output logic        imem_req,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  output logic [15:0] inst,
  output logic        inst_valid,
  output logic [15:0] PC,
  output logic [15:0] PCplus1
);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [INST_W-1:0] pc_q;
  logic [INST_W-1:0] inst_q;
  logic [INST_W-1:0] npc;
  logic              load_inst;
  logic              load_pc;

  next_pc u_next_pc (
    .pc         (pc_q),
    .inst       (inst_q),
    .pc_control (PCControl),
    .cond       (cond),
    .r_top      (rTop),
    .npc        (npc)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_inst  = 1'b0;
    load_pc    = 1'b0;
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          load_inst  = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        inst_valid = 1'b1;
        if (PCWrite) begin
          load_pc    = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      pc_q   <= RESET_PC;
      inst_q <= '0;
    end else begin
      if (load_inst) inst_q <= imem_rdata;
      if (load_pc)   pc_q   <= npc;
    end
  end

  assign PC        = pc_q;
  assign imem_addr = pc_q;
  assign inst      = inst_q;
  assign PCplus1   = pc_q + 16'd1;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
//------------------------------------------------------------------------------
// tb_fetch_unit : scoreboard-driven self-checking bench for fetch_unit.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        reset;
  logic [2:0]  PCControl;
  logic        PCWrite;
  logic        cond;
  logic [15:0] rTop;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic [15:0] inst;
  logic        inst_valid;
  logic [15:0] PC;
  logic [15:0] PCplus1;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  always #5 CLK = ~CLK;

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .PCControl  (PCControl),
    .PCWrite    (PCWrite),
    .cond       (cond),
    .rTop       (rTop),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .inst       (inst),
    .inst_valid (inst_valid),
    .PC         (PC),
    .PCplus1    (PCplus1)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pop_exp();
    if (exp_q.size() == 0) return 16'hxxxx;
    return exp_q.pop_front();
  endfunction

  // Present one word with zero wait states; bounded wait for inst_valid.
  task automatic fetch(input logic [15:0] data);
    bit seen = 0;
    exp_q.push_back(data);
    imem_rdata = data;
    imem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      if (inst_valid) begin seen = 1; break; end
    end
    imem_ready = 1'b0;
    imem_rdata = 16'hDEAD;
    check("fetch_valid", {15'd0, seen}, 16'd1);
    check("fetch_inst", inst, pop_exp());
  endtask

  task automatic retire(input logic [2:0] ctl, input logic c, input logic [15:0] rt,
                        input logic [15:0] exp_pc, input string tag);
    exp_q.push_back(exp_pc);
    PCControl = ctl;
    cond      = c;
    rTop      = rt;
    PCWrite   = 1'b1;
    @(posedge CLK); #1;
    PCWrite   = 1'b0;
    check(tag, PC, pop_exp());
    check({tag, "_addr"}, imem_addr, exp_pc);
    check({tag, "_req"}, {15'd0, imem_req}, 16'd1);
  endtask

  // Steer PC to an arbitrary value through a return.
  task automatic goto(input logic [15:0] target);
    fetch(16'h0000);
    retire(3'd4, 1'b0, target, target, "goto");
  endtask

  initial begin
    reset      = 1'b0;
    PCControl  = 3'd0;
    PCWrite    = 1'b0;
    cond       = 1'b0;
    rTop       = 16'h0000;
    imem_ready = 1'b1;
    imem_rdata = 16'h1005;

    repeat (2) @(posedge CLK);
    #1;
    check("rst_pc", PC, 16'h0000);
    check("rst_inst", inst, 16'h0000);
    check("rst_valid", {15'd0, inst_valid}, 16'd0);
    check("rst_req", {15'd0, imem_req}, 16'd1);

    @(negedge CLK);
    reset = 1'b1;
    exp_q.push_back(16'h1005);
    @(posedge CLK); #1;
    check("first_inst", inst, pop_exp());
    check("first_valid", {15'd0, inst_valid}, 16'd1);
    check("first_pc", PC, 16'h0000);
    imem_ready = 1'b0;

    // Ready while in ISSUE must not overwrite the held instruction.
    imem_ready = 1'b1;
    imem_rdata = 16'h7777;
    @(posedge CLK); #1;
    imem_ready = 1'b0;
    check("issue_hold_inst", inst, 16'h1005);
    check("issue_hold_valid", {15'd0, inst_valid}, 16'd1);

    retire(3'd0, 1'b0, 16'h0000, 16'h0001, "inc");
    check("pcplus1", PCplus1, 16'h0002);

    // Wait states, with a stray PCWrite that must be ignored in FETCH.
    PCWrite = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      check("wait_req", {15'd0, imem_req}, 16'd1);
      check("wait_valid", {15'd0, inst_valid}, 16'd0);
      check("wait_pc", PC, 16'h0001);
    end
    PCWrite = 1'b0;

    goto(16'h0010);
    fetch(16'h3FFE);
    retire(3'd1, 1'b0, 16'h0000, 16'h000E, "rel_back");
    goto(16'h0010);
    fetch(16'h3FFE);
    retire(3'd3, 1'b0, 16'h0000, 16'h0011, "cbr_nt");
    goto(16'h0010);
    fetch(16'h3FFE);
    retire(3'd3, 1'b1, 16'h0000, 16'h000E, "cbr_t");

    goto(16'h0FF0);
    fetch(16'h0020);
    retire(3'd1, 1'b0, 16'h0000, 16'h1010, "rel_fwd");

    goto(16'hFFFF);
    fetch(16'h0000);
    retire(3'd0, 1'b0, 16'h0000, 16'h0000, "wrap_inc");

    goto(16'hFFF0);
    fetch(16'h0020);
    retire(3'd1, 1'b0, 16'h0000, 16'h0010, "wrap_rel");

    goto(16'hABCD);
    fetch(16'h2123);
    retire(3'd2, 1'b0, 16'h0000, 16'hA123, "abs");

    goto(16'h0400);
    check("ret_pcplus1", PCplus1, 16'h0401);
    fetch(16'h5555);
    retire(3'd6, 1'b0, 16'h1234, 16'h0400, "hold6");
    fetch(16'h5555);
    retire(3'd7, 1'b1, 16'h1234, 16'h0400, "hold7");

    // Reset mid-fetch with a same-cycle ready that must not be captured.
    goto(16'h0200);
    check("pre_rst_pc", PC, 16'h0200);
    imem_ready = 1'b1;
    imem_rdata = 16'hBEEF;
    #2 reset = 1'b0;
    #1;
    check("async_rst_pc", PC, 16'h0000);
    check("async_rst_req", {15'd0, imem_req}, 16'd1);
    @(posedge CLK); #1;
    check("rst_no_capture", inst, 16'h0000);
    check("rst_no_valid", {15'd0, inst_valid}, 16'd0);
    imem_ready = 1'b0;
    @(negedge CLK);
    reset = 1'b1;
    @(posedge CLK); #1;
    check("post_rst_addr", imem_addr, 16'h0000);
    fetch(16'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
